// File: rtl/pg_timing_gen.sv
// -----------------------------------------------------------------------------
// pg_timing_gen
//
// Raster timing generator for the pattern-generator path. It walks a fixed
// raster (active, front porch, sync, back porch, both horizontally and
// vertically), advancing one pixel per clock while enable is high. It also
// decodes data-enable, sync and line/frame strobes for the position it is
// currently showing.
//
// Ports:
//   clk            in   pixel clock
//   reset          in   synchronous reset, active-high (has priority)
//   enable         in   advance one pixel when high, hold when low
//   h_cnt[11:0]    out  horizontal position, 0..H_TOTAL-1
//   v_cnt[11:0]    out  vertical position, 0..V_TOTAL-1
//   de             out  active-pixel flag (one cycle per advanced position)
//   hsync          out  horizontal sync, asserted level HS_POL
//   vsync          out  vertical sync, asserted level VS_POL (whole lines)
//   line_start     out  strobe at h=0 of every line
//   act_line_start out  strobe at h=0 of active lines only
//   frame_start    out  strobe at position (0,0)
//
// Every output is a flop. The flags are decoded from the *next* position,
// so they line up with h_cnt/v_cnt in the same cycle without added latency.
// -----------------------------------------------------------------------------
module pg_timing_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [11:0] h_cnt,
    output logic [11:0] v_cnt,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        act_line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Geometry sanity: reject impossible rasters at elaboration.
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h_field
        $error("pg_timing_gen: every horizontal field must be >= 1");
    end
    if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v_field
        $error("pg_timing_gen: every vertical field must be >= 1");
    end
    if (H_TOTAL > 4096) begin : g_bad_h_total
        $error("pg_timing_gen: H_TOTAL exceeds 4096");
    end
    if (V_TOTAL > 4096) begin : g_bad_v_total
        $error("pg_timing_gen: V_TOTAL exceeds 4096");
    end

    // Decode boundaries. With totals <= 4096 every one of these fits 12 bits.
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT_W  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT_W  = 12'(V_ACTIVE);
    localparam logic [11:0] H_HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    // started is clear after reset so the first advance lands on (0,0)
    // instead of stepping past it.
    logic        started;
    logic [11:0] h_nxt;
    logic [11:0] v_nxt;
    logic        de_nxt;
    logic        hs_nxt;
    logic        vs_nxt;
    logic        h_zero;

    always_comb begin
        h_nxt = '0;
        v_nxt = '0;
        if (started) begin
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 12'd1;
            end else begin
                h_nxt = h_cnt + 12'd1;
                v_nxt = v_cnt;
            end
        end
        h_zero = (h_nxt == '0);
        de_nxt = (h_nxt < H_ACT_W) && (v_nxt < V_ACT_W);
        hs_nxt = (h_nxt >= H_HS_BEG && h_nxt < H_HS_END) ? HS_POL : ~HS_POL;
        vs_nxt = (v_nxt >= V_VS_BEG && v_nxt < V_VS_END) ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            started        <= 1'b0;
            h_cnt          <= '0;
            v_cnt          <= '0;
            de             <= 1'b0;
            hsync          <= ~HS_POL;
            vsync          <= ~VS_POL;
            line_start     <= 1'b0;
            act_line_start <= 1'b0;
            frame_start    <= 1'b0;
        end else if (enable) begin
            started        <= 1'b1;
            h_cnt          <= h_nxt;
            v_cnt          <= v_nxt;
            de             <= de_nxt;
            hsync          <= hs_nxt;
            vsync          <= vs_nxt;
            line_start     <= h_zero;
            act_line_start <= h_zero && (v_nxt < V_ACT_W);
            frame_start    <= h_zero && (v_nxt == '0);
        end else begin
            // Stall: position and syncs hold; per-pixel flags are one-shot
            // so a held position is never counted twice downstream.
            de             <= 1'b0;
            line_start     <= 1'b0;
            act_line_start <= 1'b0;
            frame_start    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pg_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_pg_timing_gen
//
// Directed bench on a small raster: H 8/2/3/3 (H_TOTAL=16), V 4/1/2/1
// (V_TOTAL=8), so one frame is 128 enabled cycles. Two instances share the
// stimulus: u_dut with positive sync polarity and u_dut_n with negative.
// Expected values are hand-derived from that geometry.
// -----------------------------------------------------------------------------
module tb_pg_timing_gen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;

    always #5 clk = ~clk;

    logic [11:0] h_cnt, v_cnt, h_cnt_n, v_cnt_n;
    logic de, hsync, vsync, line_start, act_line_start, frame_start;
    logic de_n, hsync_n, vsync_n, line_start_n, act_line_start_n, frame_start_n;

    pg_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .de(de), .hsync(hsync), .vsync(vsync),
        .line_start(line_start), .act_line_start(act_line_start),
        .frame_start(frame_start)
    );

    pg_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_dut_n (
        .clk(clk), .reset(reset), .enable(enable),
        .h_cnt(h_cnt_n), .v_cnt(v_cnt_n), .de(de_n), .hsync(hsync_n),
        .vsync(vsync_n), .line_start(line_start_n),
        .act_line_start(act_line_start_n), .frame_start(frame_start_n)
    );

    // ---------------- bookkeeping ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    int c_de, c_hs, c_vs, c_hs_n, c_vs_n, c_fs, c_ls, c_als, c_bad;

    task automatic clear_counts();
        c_de = 0; c_hs = 0; c_vs = 0; c_hs_n = 0; c_vs_n = 0;
        c_fs = 0; c_ls = 0; c_als = 0; c_bad = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Full state of the positive-polarity instance in one call.
    task automatic chk_state(input string tag, input int eh, input int ev,
                             input bit ede, input bit ehs, input bit evs,
                             input bit els, input bit eals, input bit efs);
        chk({tag, ".h"},   32'(h_cnt),          32'(eh));
        chk({tag, ".v"},   32'(v_cnt),          32'(ev));
        chk({tag, ".de"},  32'(de),             32'(ede));
        chk({tag, ".hs"},  32'(hsync),          32'(ehs));
        chk({tag, ".vs"},  32'(vsync),          32'(evs));
        chk({tag, ".ls"},  32'(line_start),     32'(els));
        chk({tag, ".als"}, 32'(act_line_start), 32'(eals));
        chk({tag, ".fs"},  32'(frame_start),    32'(efs));
    endtask

    // ---------------- driver ----------------
    // One clock; outputs are sampled 1 ns after the edge and tallied.
    task automatic step();
        @(posedge clk);
        #1;
        if (de) c_de++;
        if (hsync) begin
            c_hs++;
            if (h_cnt < 12'd10 || h_cnt > 12'd12) c_bad++;
        end
        if (vsync) begin
            c_vs++;
            if (v_cnt < 12'd5 || v_cnt > 12'd6) c_bad++;
        end
        if (!hsync_n) begin
            c_hs_n++;
            if (h_cnt_n < 12'd10 || h_cnt_n > 12'd12) c_bad++;
        end
        if (!vsync_n) begin
            c_vs_n++;
            if (v_cnt_n < 12'd5 || v_cnt_n > 12'd6) c_bad++;
        end
        if (frame_start) c_fs++;
        if (line_start) c_ls++;
        if (act_line_start) begin
            c_als++;
            if (v_cnt >= 12'd4) c_bad++;
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int pos_bad;
        clear_counts();

        // Reset for 3 cycles.
        reset = 1'b1; enable = 1'b0;
        steps(3);
        chk_state("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset.hs_n", 32'(hsync_n), 32'd1);
        chk("reset.vs_n", 32'(vsync_n), 32'd1);

        // Two full frames from release.
        reset = 1'b0; enable = 1'b1;
        clear_counts();
        pos_bad = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (h_cnt !== 12'(i % 16) || v_cnt !== 12'((i / 16) % 8)) pos_bad++;
            if (i == 0)  chk_state("first", 0, 0, 1, 0, 0, 1, 1, 1);
            if (i == 7)  chk("de_h7", 32'(de), 32'd1);
            if (i == 8)  chk("de_h8", 32'(de), 32'd0);
            if (i == 10) chk("hs_h10", 32'(hsync), 32'd1);
            if (i == 13) chk("hs_h13", 32'(hsync), 32'd0);
            if (i == 16) chk_state("line1", 0, 1, 1, 0, 0, 1, 1, 0);
            if (i == 80) chk_state("line5", 0, 5, 0, 0, 1, 1, 0, 0);
        end
        chk("pos_seq",   32'(pos_bad), 32'd0);
        chk("cnt_de",    32'(c_de),    32'd64);
        chk("cnt_hs",    32'(c_hs),    32'd48);
        chk("cnt_vs",    32'(c_vs),    32'd64);
        chk("cnt_hs_n",  32'(c_hs_n),  32'd48);
        chk("cnt_vs_n",  32'(c_vs_n),  32'd64);
        chk("cnt_fs",    32'(c_fs),    32'd2);
        chk("cnt_ls",    32'(c_ls),    32'd16);
        chk("cnt_als",   32'(c_als),   32'd8);
        chk("sync_rng",  32'(c_bad),   32'd0);
        chk_state("end_f2", 15, 7, 0, 0, 0, 0, 0, 0);

        // Frame wrap, then stall at (3,2) for 5 cycles.
        clear_counts();
        step();
        chk_state("wrap1", 0, 0, 1, 0, 0, 1, 1, 1);
        steps(35);
        chk_state("at_3_2", 3, 2, 1, 0, 0, 0, 0, 0);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_state("stall", 3, 2, 0, 0, 0, 0, 0, 0);
        end
        enable = 1'b1;
        step();
        chk_state("resume", 4, 2, 1, 0, 0, 0, 0, 0);
        steps(91);
        chk("stall_h_end", 32'(h_cnt), 32'd15);
        chk("stall_v_end", 32'(v_cnt), 32'd7);
        chk("stall_de_cnt", 32'(c_de), 32'd32);
        chk("stall_fs_cnt", 32'(c_fs), 32'd1);

        // Mid-frame reset at (6,3).
        steps(55);
        chk_state("at_6_3", 6, 3, 1, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        chk_state("midreset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("midreset.hs_n", 32'(hsync_n), 32'd1);
        reset = 1'b0; enable = 1'b0;
        step();
        chk_state("idle_after_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        enable = 1'b1;
        step();
        chk_state("restart", 0, 0, 1, 0, 0, 1, 1, 1);

        // Reset with enable held high: reset wins.
        steps(20);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk_state("rst_en", 0, 0, 0, 0, 0, 0, 0, 0);
        end
        reset = 1'b0;
        step();
        chk_state("rst_en_rel", 0, 0, 1, 0, 0, 1, 1, 1);

        // Run to the last pixel of the frame and across the wrap.
        steps(127);
        chk_state("last_px", 15, 7, 0, 0, 0, 0, 0, 0);
        step();
        chk_state("wrap2", 0, 0, 1, 0, 0, 1, 1, 1);
        chk("wrap2.vs_n", 32'(vsync_n), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pg_timing_gen.md
Name: pg_timing_gen

Overview:
- Raster timing generator for the pattern-generator path; produces horizontal/vertical position counters, data-enable, sync and line/frame strobes.
- Sits directly upstream of the pattern stages.
- h_cnt is the position input of the downstream per-line step counter, which act_line_start re-arms at each active line start.
- Fixed geometry set by parameters; one pixel per enabled clock.

Parameters:
H_ACTIVE, 1920, active pixels per line
H_FP, 88, horizontal front porch (pixels)
H_SYNC, 44, hsync width (pixels)
H_BP, 148, horizontal back porch (pixels)
V_ACTIVE, 1080, active lines per frame
V_FP, 4, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 36, vertical back porch (lines)
HS_POL, 1, hsync asserted level
VS_POL, 1, vsync asserted level

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous reset, active-high
enable  in  1  advance one pixel per cycle when high
h_cnt  out  12  horizontal position, 0..H_TOTAL-1
v_cnt  out  12  vertical position, 0..V_TOTAL-1
de  out  1  active-pixel flag
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
line_start  out  1  strobe, first pixel of every line
act_line_start  out  1  strobe, first pixel of active lines only
frame_start  out  1  strobe, pixel (0,0)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Derived widths: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must be ≤4096. Every field must be ≥1. Violations are elaboration errors.
- Line order: active, front porch, sync, back porch. Frame order is the same.
- Reset (any cycle, including mid-frame): next edge sets h_cnt=0, v_cnt=0, de=0, all strobes 0, hsync=~HS_POL, vsync=~VS_POL. An internal started flag is cleared. Reset has priority over enable.
- Advance: every edge with reset=0 and enable=1 loads the next position.
  - If started=0, the next position is (0,0) and started is set.
  - Otherwise h=h+1. If h==H_TOTAL-1, h wraps to 0 and v increments. If v==V_TOTAL-1 at that wrap, v wraps to 0.
- All outputs are registered and aligned to the position shown in h_cnt/v_cnt in the same cycle. There is no extra latency between counters and flags.
- Flag decode on an advance edge, for the loaded position (h,v):
  - de = (h<H_ACTIVE) && (v<V_ACTIVE)
  - hsync = HS_POL when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
  - vsync = VS_POL when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (whole lines, changes at h=0), else ~VS_POL
  - line_start = (h==0)
  - act_line_start = (h==0) && (v<V_ACTIVE)
  - frame_start = (h==0) && (v==0)
- Stall (reset=0, enable=0):
  - h_cnt, v_cnt, hsync, vsync hold.
  - de, line_start, act_line_start, frame_start go to 0.
  - Each position's strobes and de are therefore high for exactly one cycle.
  - Resuming loads the position following the held one. No pixel is skipped or repeated.
- The first advance after reset always yields frame_start=line_start=act_line_start=de=1.
- No combinational path from inputs to outputs.

Test Plan:
- Use small geometry for every scenario: H 8/2/3/3 (H_TOTAL=16), V 4/1/2/1 (V_TOTAL=8), HS_POL=VS_POL=1 unless noted; one frame = 128 enabled cycles.
- Reset 3 cycles, then enable=1 -> first cycle after release shows h=0, v=0, de=1, frame_start=line_start=act_line_start=1. de stays high for h=0..7 and drops at h=8. After h=15, next cycle shows h=0, v=1, line_start=1, frame_start=0.
- Run 2 frames -> hsync high exactly at h=10..12 on every line. vsync high for all 32 cycles of v=5..6. frame_start every 128 cycles. line_start 8 per frame. act_line_start 4 per frame (v=0..3). de 32 cycles per frame. Rerun with HS_POL=0 -> hsync low only at h=10..12.
- Drop enable for 5 cycles while at h=3, v=2 -> h/v/hsync/vsync hold, de and strobes 0. First cycle after re-enable shows h=4, v=2, de=1. Total de count for that frame is still 32.
- Assert reset one cycle at h=6, v=3 -> next cycle h=0, v=0, de=0, hsync=vsync=0, strobes 0. First enabled cycle after release shows (0,0) with frame_start=1.
- Assert reset and enable together for 2 cycles -> outputs stay in reset state (reset priority). Wrap check: enabled cycle after h=15, v=7 shows h=0, v=0, frame_start=1, vsync=0.
